// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM state encodings,
// push step codes and the default interrupt vector.
package interrupt_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_PUSH    = 3'd2,
    ST_VECTOR  = 3'd3,
    ST_SERVICE = 3'd4
  } int_state_t;

  // int_counter value seen by the memory stage for each push
  localparam logic [1:0] INT_STEP_PC_HI = 2'd0;
  localparam logic [1:0] INT_STEP_PC_LO = 2'd1;
  localparam logic [1:0] INT_STEP_CCR   = 2'd2;

  localparam logic [31:0] INT_DEFAULT_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/interrupt_controller_sync.sv
// int_sync: multi-flop synchroniser for an asynchronous request followed by
// a rising-edge detector; rise is a one-cycle pulse in the clk domain.
module int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      last <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], async_in};
      last <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~last;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt entry sequencer: accepts a synchronised request at a safe boundary,
// flushes, pushes PC/CCR, loads the vector and waits for RTI. Macro INT_PENDING_LATCH_EN.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR = INT_DEFAULT_VECTOR,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        int_req,
  input  logic        pipe_ready,
  input  logic [31:0] pc_in,
  input  logic [2:0]  ccr_in,
  input  logic        rti,
  output logic        int_active,
  output logic [1:0]  int_counter,
  output logic        push,
  output logic [15:0] push_data,
  output logic        flush,
  output logic        pc_load,
  output logic [31:0] pc_load_addr,
  output logic        in_service
);

  int_state_t  state, next_state;
  logic [1:0]  step, next_step;
  logic        pending;
  logic [31:0] cap_pc;
  logic [2:0]  cap_ccr;
  logic        req_rise;
  logic        accept;
  logic        edge_allowed;

  logic        flush_d, push_d, pc_load_d, in_service_d;
  logic [1:0]  int_counter_d;
  logic [15:0] push_data_d;

  int_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (RESET),
    .async_in (int_req),
    .rise     (req_rise)
  );

  assign accept = (state == ST_IDLE) && pending && pipe_ready;

`ifdef INT_PENDING_LATCH_EN
  assign edge_allowed = 1'b1;
`else
  assign edge_allowed = (state == ST_IDLE);
`endif

  // An edge that arrives while a request is already pending (or on the accept edge) merges into it
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      pending <= 1'b0;
    end else if (accept) begin
      pending <= 1'b0;
    end else if (req_rise && edge_allowed) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      cap_pc  <= '0;
      cap_ccr <= '0;
    end else if (accept) begin
      cap_pc  <= pc_in;
      cap_ccr <= ccr_in;
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
      step  <= INT_STEP_PC_HI;
    end else begin
      state <= next_state;
      step  <= next_step;
    end
  end

  always_comb begin
    next_state = state;
    next_step  = step;
    case (state)
      ST_IDLE:    if (accept) next_state = ST_FLUSH;
      ST_FLUSH: begin
        next_state = ST_PUSH;
        next_step  = INT_STEP_PC_HI;
      end
      ST_PUSH: begin
        if (step == INT_STEP_CCR) next_state = ST_VECTOR;
        else                      next_step  = step + 2'd1;
      end
      ST_VECTOR:  next_state = ST_SERVICE;
      ST_SERVICE: if (rti) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered without a cycle of lag
  always_comb begin
    flush_d       = (next_state == ST_FLUSH);
    push_d        = (next_state == ST_PUSH);
    pc_load_d     = (next_state == ST_VECTOR);
    in_service_d  = (next_state != ST_IDLE);
    int_counter_d = push_d ? next_step : 2'd0;
    push_data_d   = '0;
    if (push_d) begin
      case (next_step)
        INT_STEP_PC_HI: push_data_d = cap_pc[31:16];
        INT_STEP_PC_LO: push_data_d = cap_pc[15:0];
        default:        push_data_d = {13'b0, cap_ccr};
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      flush       <= 1'b0;
      push        <= 1'b0;
      int_active  <= 1'b0;
      int_counter <= 2'd0;
      push_data   <= '0;
      pc_load     <= 1'b0;
      in_service  <= 1'b0;
    end else begin
      flush       <= flush_d;
      push        <= push_d;
      int_active  <= push_d;
      int_counter <= int_counter_d;
      push_data   <= push_data_d;
      pc_load     <= pc_load_d;
      in_service  <= in_service_d;
    end
  end

  assign pc_load_addr = VECTOR_ADDR;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: a timeline model of the entry
// sequence checked every cycle, plus hand-computed directed expectations.
module tb_interrupt_controller;

  localparam int SYNC = 2;
  localparam logic [31:0] VEC = 32'h0000_0000;
`ifdef INT_PENDING_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET;
  logic        int_req, pipe_ready, rti;
  logic [31:0] pc_in;
  logic [2:0]  ccr_in;
  logic        int_active, push, flush, pc_load, in_service;
  logic [1:0]  int_counter;
  logic [15:0] push_data;
  logic [31:0] pc_load_addr;

  int checks = 0;
  int errors = 0;
  int dut_vec = 0;

  interrupt_controller #(.VECTOR_ADDR(VEC), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .RESET        (RESET),
    .int_req      (int_req),
    .pipe_ready   (pipe_ready),
    .pc_in        (pc_in),
    .ccr_in       (ccr_in),
    .rti          (rti),
    .int_active   (int_active),
    .int_counter  (int_counter),
    .push         (push),
    .push_data    (push_data),
    .flush        (flush),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .in_service   (in_service)
  );

  always #5 clk = ~clk;

  // Model: phase counts cycles since accept (0 idle, 1 flush, 2..4 pushes, 5 vector, 6 service)
  int          m_phase;
  logic        m_pending;
  logic [31:0] m_pc;
  logic [2:0]  m_ccr;
  logic [SYNC:0] hist;
  logic        m_rise, m_accept;

  assign m_rise   = hist[SYNC-1] & ~hist[SYNC];
  assign m_accept = (m_phase == 0) && m_pending && pipe_ready;

  always @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      m_phase   <= 0;
      m_pending <= 1'b0;
      m_pc      <= '0;
      m_ccr     <= '0;
      hist      <= '0;
    end else begin
      hist <= {hist[SYNC-1:0], int_req};
      if (m_accept) begin
        m_pending <= 1'b0;
        m_pc      <= pc_in;
        m_ccr     <= ccr_in;
      end else if (m_rise && (m_phase == 0 || LATCH)) begin
        m_pending <= 1'b1;
      end
      if (m_accept)                       m_phase <= 1;
      else if (m_phase >= 1 && m_phase <= 5) m_phase <= m_phase + 1;
      else if (m_phase == 6 && rti)       m_phase <= 0;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    logic        e_push;
    logic [15:0] e_data;
    e_push = (m_phase >= 2 && m_phase <= 4);
    case (m_phase)
      2:       e_data = m_pc[31:16];
      3:       e_data = m_pc[15:0];
      4:       e_data = {13'b0, m_ccr};
      default: e_data = 16'h0;
    endcase
    check_output("model_flush",      32'(flush),        32'(m_phase == 1));
    check_output("model_push",       32'(push),         32'(e_push));
    check_output("model_int_active", 32'(int_active),   32'(e_push));
    check_output("model_counter",    32'(int_counter),  e_push ? 32'(m_phase - 2) : 32'd0);
    check_output("model_push_data",  32'(push_data),    32'(e_data));
    check_output("model_pc_load",    32'(pc_load),      32'(m_phase == 5));
    check_output("model_pc_addr",    pc_load_addr,      VEC);
    check_output("model_in_service", 32'(in_service),   32'(m_phase != 0));
    if (pc_load === 1'b1) dut_vec <= dut_vec + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic ready, input logic [31:0] pc, input logic [2:0] ccr);
    pipe_ready = ready;
    pc_in      = pc;
    ccr_in     = ccr;
  endtask

  task automatic pulse_rti();
    rti = 1'b1;
    tick(1);
    rti = 1'b0;
  endtask

  // Expects to be called on the negedge where flush is visible
  task automatic check_sequence(input logic [15:0] hi, input logic [15:0] lo, input logic [15:0] cc);
    tick(1);
    check_output("push0_data", 32'(push_data), 32'(hi));
    check_output("push0_cnt",  32'(int_counter), 32'd0);
    tick(1);
    check_output("push1_data", 32'(push_data), 32'(lo));
    check_output("push1_cnt",  32'(int_counter), 32'd1);
    tick(1);
    check_output("push2_data", 32'(push_data), 32'(cc));
    check_output("push2_cnt",  32'(int_counter), 32'd2);
    tick(1);
    check_output("vec_load",   32'(pc_load), 32'd1);
    check_output("vec_addr",   pc_load_addr, 32'h0000_0000);
    tick(1);
    check_output("svc_hold",   32'(in_service), 32'd1);
    check_output("svc_noload", 32'(pc_load), 32'd0);
  endtask

  initial begin
    int vec_before;
    RESET = 1'b0; int_req = 1'b0; rti = 1'b0;
    apply_stimulus(1'b0, 32'h0, 3'b0);
    tick(3);
    check_output("rst_flush", 32'(flush), 32'd0);
    check_output("rst_push",  32'(push), 32'd0);
    check_output("rst_svc",   32'(in_service), 32'd0);
    check_output("rst_addr",  pc_load_addr, 32'h0000_0000);
    #2 RESET = 1'b1;
    tick(2);

    $display("[TB] basic sequence");
    apply_stimulus(1'b1, 32'h0001_2345, 3'b101);
    int_req = 1'b1;
    tick(4);
    check_output("basic_flush", 32'(flush), 32'd1);
    check_output("basic_svc",   32'(in_service), 32'd1);
    int_req = 1'b0;
    pc_in   = 32'hDEAD_BEEF;
    check_sequence(16'h0001, 16'h2345, 16'h0005);
    pulse_rti();
    check_output("basic_rti", 32'(in_service), 32'd0);
    tick(2);

    $display("[TB] gated entry");
    apply_stimulus(1'b0, 32'h1111_2222, 3'b111);
    int_req = 1'b1;
    tick(3);
    int_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_output("gated_noflush", 32'(flush | in_service), 32'd0);
    end
    apply_stimulus(1'b1, 32'h00AB_CDEF, 3'b011);
    tick(1);
    check_output("gated_flush", 32'(flush), 32'd1);
    apply_stimulus(1'b1, 32'h5555_6666, 3'b000);
    check_sequence(16'h00AB, 16'hCDEF, 16'h0003);
    pulse_rti();
    tick(2);

    $display("[TB] spurious rti");
    pulse_rti();
    tick(1);
    check_output("spur_svc",   32'(in_service), 32'd0);
    check_output("spur_push",  32'(push | flush | pc_load), 32'd0);
    tick(2);

    $display("[TB] nested request");
    apply_stimulus(1'b1, 32'h00C0_FFEE, 3'b001);
    int_req = 1'b1;
    tick(4);
    int_req = 1'b0;
    tick(5);
    check_output("nest_in_svc", 32'(in_service), 32'd1);
    int_req = 1'b1;
    tick(2);
    int_req = 1'b0;
    tick(4);
    #1 vec_before = dut_vec;
    tick(1);
    pulse_rti();
    tick(12);
    #1 check_output("nest_second", 32'(dut_vec - vec_before), LATCH ? 32'd1 : 32'd0);
    tick(1);
    pulse_rti();
    tick(3);
    check_output("nest_idle", 32'(in_service), 32'd0);

    $display("[TB] reset mid-sequence");
    apply_stimulus(1'b1, 32'h1234_5678, 3'b010);
    int_req = 1'b1;
    tick(4);
    int_req = 1'b0;
    tick(2);
    check_output("mid_step1", 32'(int_counter), 32'd1);
    #2 RESET = 1'b0;
    #1;
    check_output("mid_push",   32'(push | int_active), 32'd0);
    check_output("mid_cnt",    32'(int_counter), 32'd0);
    check_output("mid_data",   32'(push_data), 32'd0);
    check_output("mid_svc",    32'(in_service | flush | pc_load), 32'd0);
    tick(2);
    #2 RESET = 1'b1;
    #1 vec_before = dut_vec;
    tick(10);
    #1 check_output("mid_quiet", 32'(dut_vec - vec_before), 32'd0);
    check_output("mid_idle", 32'(in_service), 32'd0);

    $display("[TB] glitch merge");
    tick(1);
    apply_stimulus(1'b0, 32'h0BAD_F00D, 3'b110);
    vec_before = dut_vec;
    int_req = 1'b1; tick(1);
    int_req = 1'b0; tick(2);
    int_req = 1'b1; tick(1);
    int_req = 1'b0; tick(6);
    pipe_ready = 1'b1;
    tick(15);
    #1 check_output("merge_once", 32'(dut_vec - vec_before), 32'd1);
    tick(1);
    pulse_rti();
    tick(3);
    check_output("merge_idle", 32'(in_service), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
